// File: rtl/prbs_gen_check.sv
// -----------------------------------------------------------------------------
// prbs_gen_check
// PRBS generator plus self-synchronising checker. The generator drives a pad
// (or a loopback). The checker seeds itself from the received stream until
// LOCK_CNT consecutive bits are predicted correctly. After that it runs
// free, so each received bit error shows up as exactly one mismatch.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous, active-low reset
//   en          bit enable; all state advances only when high
//   mode[1:0]   polynomial: 0=PRBS7 1=PRBS15 2=PRBS23 3=PRBS31
//   inject_err  invert the next generated bit (only with en)
//   clr_cnt     synchronous clear of err_cnt (wins over an increment)
//   rx_in       received bit, sampled when en is high
//   gen_out     registered generated bit
//   locked      checker is in LOCKED
//   err_pulse   one-cycle pulse per error detected while LOCKED
//   err_cnt     saturating error count
// -----------------------------------------------------------------------------
module prbs_gen_check #(
  parameter int CNT_W      = 16,
  parameter int LOCK_CNT   = 64,
  parameter int WIN        = 256,
  parameter int UNLOCK_ERR = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             inject_err,
  input  logic             clr_cnt,
  input  logic             rx_in,
  output logic             gen_out,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int POS_W  = $clog2(WIN);
  localparam int WERR_W = $clog2(UNLOCK_ERR + 1);

  localparam logic [RUN_W-1:0]  RUN_LOCK = RUN_W'(LOCK_CNT);
  localparam logic [POS_W-1:0]  POS_LAST = POS_W'(WIN - 1);
  localparam logic [WERR_W-1:0] WERR_LIM = WERR_W'(UNLOCK_ERR);

  state_e              state_q, state_d;
  logic [30:0]         gen_q, gen_d;
  logic [30:0]         chk_q, chk_d;
  logic [1:0]          mode_q;
  logic                gen_out_q, gen_out_d;
  logic                err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [POS_W-1:0]    win_pos_q, win_pos_d;
  logic [WERR_W-1:0]   win_err_q, win_err_d;

  logic                gen_fb, gen_msb, pred, mis;
  logic                mode_chg, win_wrap, cnt_inc;
  logic [WERR_W-1:0]   win_err_inc;

  // Tap selection. Taps are 1-indexed (a, b) with a = L, so the generator
  // output bit gen[L-1] is also the first tap.
  always_comb begin
    gen_fb  = 1'b0;
    gen_msb = 1'b0;
    pred    = 1'b0;
    case (mode_q)
      2'd0: begin
        gen_fb  = gen_q[6] ^ gen_q[5];
        gen_msb = gen_q[6];
        pred    = chk_q[6] ^ chk_q[5];
      end
      2'd1: begin
        gen_fb  = gen_q[14] ^ gen_q[13];
        gen_msb = gen_q[14];
        pred    = chk_q[14] ^ chk_q[13];
      end
      2'd2: begin
        gen_fb  = gen_q[22] ^ gen_q[17];
        gen_msb = gen_q[22];
        pred    = chk_q[22] ^ chk_q[17];
      end
      default: begin
        gen_fb  = gen_q[30] ^ gen_q[27];
        gen_msb = gen_q[30];
        pred    = chk_q[30] ^ chk_q[27];
      end
    endcase
  end

  assign mis         = rx_in ^ pred;
  assign mode_chg    = (mode != mode_q);
  assign win_wrap    = (win_pos_q == POS_LAST);
  assign win_err_inc = win_err_q + WERR_W'(mis);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    gen_d       = gen_q;
    chk_d       = chk_q;
    gen_out_d   = gen_out_q;
    run_d       = run_q;
    win_pos_d   = win_pos_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    cnt_inc     = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (mode_chg) begin
      // A new polynomial restarts both LFSRs and the lock search, whether or not en is high.
      gen_d     = '1;
      chk_d     = '1;
      state_d   = ST_SEARCH;
      run_d     = '0;
      win_pos_d = '0;
      win_err_d = '0;
    end else if (en) begin
      gen_d     = {gen_q[29:0], gen_fb};
      // The injection touches only the output bit; the LFSR keeps its sequence.
      gen_out_d = gen_msb ^ inject_err;
      case (state_q)
        ST_SEARCH: begin
          // Self-seed from the line so the checker aligns to any phase.
          chk_d = {chk_q[29:0], rx_in};
          if (mis) begin
            run_d = '0;
          end else if (run_q + RUN_W'(1) == RUN_LOCK) begin
            state_d   = ST_LOCKED;
            run_d     = '0;
            win_pos_d = '0;
            win_err_d = '0;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end
        ST_LOCKED: begin
          // Free-run on predictions so a bad bit is not fed back into the taps.
          chk_d       = {chk_q[29:0], pred};
          err_pulse_d = mis;
          cnt_inc     = mis;
          if (win_err_inc == WERR_LIM) begin
            state_d   = ST_SEARCH;
            run_d     = '0;
            win_pos_d = '0;
            win_err_d = '0;
          end else if (win_wrap) begin
            // An error on the last bit of a window belongs to that window.
            win_pos_d = '0;
            win_err_d = '0;
          end else begin
            win_pos_d = win_pos_q + POS_W'(1);
            win_err_d = win_err_inc;
          end
        end
      endcase
    end

    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (cnt_inc && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    mode_q <= mode;
    if (!rst_n) begin
      state_q     <= ST_SEARCH;
      gen_q       <= '1;
      chk_q       <= '1;
      gen_out_q   <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      run_q       <= '0;
      win_pos_q   <= '0;
      win_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      gen_q       <= gen_d;
      chk_q       <= chk_d;
      gen_out_q   <= gen_out_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      run_q       <= run_d;
      win_pos_q   <= win_pos_d;
      win_err_q   <= win_err_d;
    end
  end

  assign gen_out   = gen_out_q;
  assign locked    = (state_q == ST_LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/prbs_gen_check.md
# prbs_gen_check

Parametrised PRBS generator and self-synchronising checker for pattern-based link and pad testing. It supports four polynomials (PRBS7/15/23/31) selectable at run time. It injects single-bit errors on demand, locks onto an incoming stream with a two-state lock FSM, and accumulates a saturating error count. It sits between the top-level I/O wrapper and the pins: `gen_out` drives an output pad and `rx_in` is taken from an input pad, or looped back for self-test.

## Interface
- `CNT_W`, 16: width of the error counter, 1..32.
- `LOCK_CNT`, 64: consecutive matching bits required to enter LOCKED; must be ≥ 32.
- `WIN`, 256: bit-window length used for loss-of-lock detection; must be ≥ 2.
- `UNLOCK_ERR`, 8: errors within one window that force loss of lock; must be ≤ `WIN`.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `en`  in  1: bit enable; generator, checker and all counters advance only when high.
- `mode`  in  2: polynomial select. 0 = x^7+x^6+1, 1 = x^15+x^14+1, 2 = x^23+x^18+1, 3 = x^31+x^28+1.
- `inject_err`  in  1: when high with `en`, the next generated bit is inverted.
- `clr_cnt`  in  1: synchronous clear of `err_cnt`.
- `rx_in`  in  1: received bit, sampled when `en` is high.
- `gen_out`  out  1: generated PRBS bit (registered).
- `locked`  out  1: checker is in the LOCKED state.
- `err_pulse`  out  1: one-cycle pulse for each detected error while LOCKED.
- `err_cnt`  out  CNT_W: saturating error count.

## Operation
- Polynomial length L is 7, 15, 23 or 31 according to `mode`. Taps are (a, b) = (7,6), (15,14), (23,18) or (31,28), 1-indexed.
- **Generator**
  - `gen` is a 31-bit register, reset to all ones.
  - Each enabled cycle: `gen <= {gen[29:0], gen[a-1]^gen[b-1]}`.
  - `gen_out <= gen[L-1] ^ inject_err`.
  - The injection affects only the output bit, never the register state.
- **Mode change**
  - `mode` is registered internally.
  - When `mode` differs from the registered value, on the next cycle (regardless of `en`) `gen` and `chk` reload to all ones and the FSM returns to SEARCH.
  - `err_cnt` is not cleared by a mode change.
- **Checker**
  - `chk` is a 31-bit register, reset to all ones.
  - Prediction `p = chk[a-1]^chk[b-1]`; `mis = rx_in ^ p`. Both are evaluated only on enabled cycles.
- **Lock FSM**
  - SEARCH (reset state):
    - `chk <= {chk[29:0], rx_in}` (self-seeding).
    - `run` counts consecutive `mis==0` and clears to 0 on `mis==1`.
    - When `run` reaches `LOCK_CNT`, go to LOCKED and clear the window counters.
  - LOCKED:
    - `chk <= {chk[29:0], p}` (free-running), so each received bit error produces exactly one `mis`.
    - On `mis`: `err_pulse` fires, `err_cnt` increments, `win_err` increments.
    - `win_pos` counts enabled bits 0..WIN-1 and wraps. At wrap, `win_err` clears to 0.
    - If `win_err` reaches `UNLOCK_ERR` (counting the current error), go to SEARCH and clear `run`.
    - `chk` is not reloaded on loss of lock; SEARCH self-seeds.
- **Error counter**
  - `err_cnt` saturates at 2^CNT_W−1.
  - `clr_cnt` has priority over an increment in the same cycle, so the result is 0.
  - Errors are never counted in SEARCH.

## Timing
- Reset values: `gen_out`=0, `locked`=0, `err_pulse`=0, `err_cnt`=0. Internally: `gen`=`chk`=all ones, FSM=SEARCH, `run`=`win_pos`=`win_err`=0, registered mode = `mode` input.
- Reset has priority over all other inputs.
- Reset mid-operation returns everything to the reset values at the next edge.
- `gen_out` is registered: a bit computed in cycle n appears after edge n.
- `err_pulse` and the `err_cnt` update occur on the edge after the erroneous `rx_in` is sampled. `err_pulse` is high for exactly one cycle per error.
- `locked` rises on the same edge that completes `run==LOCK_CNT`, and falls on the same edge as the `UNLOCK_ERR`-th error.
- `en` low freezes all state and holds `err_pulse` at 0. `clr_cnt` and mode reload still act while `en` is low.
- Error-free loopback (`rx_in = gen_out`): `locked` is asserted within L + `LOCK_CNT` + 2 enabled cycles.

## Test plan
- **PRBS7 loopback, defaults:** `locked`=1 within 73 enabled cycles. `gen_out` is periodic with period 127 and contains 64 ones per period. `err_cnt` stays at 0 for 10 000 cycles.
- **Single injection, mode 3, locked:** one `inject_err` pulse gives exactly one `err_pulse`, `err_cnt`=1 and `locked` stays 1. With `clr_cnt` asserted in the same cycle as the detected error, `err_cnt`=0.
- **Burst loss of lock:** 8 injections within one 256-bit window cause `locked` to fall on the 8th error and `err_cnt`=8. 7 injections spread over two windows (4 in one, 3 in the next) keep `locked`=1.
- **Saturation, `CNT_W`=4:** 20 isolated errors, each spaced > `WIN` apart, give `err_cnt`=15, with the pulse still asserted for every error.
- **Mode switch 0→2 while locked:** `locked` drops the next cycle, `err_cnt` is retained, the checker relocks on PRBS23 within 89 cycles, and `gen_out` period is 8 388 607.
- **Stall and reset:** `en` low for 50 cycles mid-stream leaves all outputs frozen, and lock and count are unchanged after resume. `rst_n`=0 for 1 cycle while LOCKED restores all reset values at the next edge.
